filter_scan_ctrl: RTL and testbench
===================================

FILTER_SCAN_CTRL -- requirements
Module: filter_scan_ctrl

Interface
REQ-001 SHALL have parameter NumCh, default 8, number of filtered input channels.
REQ-002 SHALL have parameter CtrWidth, default 8, per-channel counter/threshold width.
REQ-003 SHALL have parameter DefThresh, default 3, reset value of every channel threshold.
REQ-004 SHALL have parameter EvtDepth, default 4, event queue depth (power of 2, at least 2).
REQ-005 clk_i  input  1  sole clock, all state on posedge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 raw_i  input  NumCh  pre-synchronized raw inputs.
REQ-008 scan_en_i  input  1  scan advance/update enable.
REQ-009 cfg_we_i  input  1  config write strobe, single cycle.
REQ-010 cfg_ch_i  input  $clog2(NumCh)  target channel of config write.
REQ-011 cfg_en_i  input  1  filter enable written to target channel.
REQ-012 cfg_thresh_i  input  CtrWidth  threshold written to target channel.
REQ-013 filt_o  output  NumCh  per-channel filtered value.
REQ-014 evt_valid_o  output  1  event queue non-empty.
REQ-015 evt_ready_i  input  1  consumer accepts head event.
REQ-016 evt_ch_o  output  $clog2(NumCh)  channel of head event.
REQ-017 evt_val_o  output  1  new stored value of head event.
REQ-018 ovf_o  output  1  sticky event-dropped flag.
REQ-019 ovf_clr_i  input  1  clears ovf_o.

Function
REQ-020 SHALL keep per channel: sample, stored, ctr (CtrWidth), thresh (CtrWidth), en.
REQ-021 SHALL hold scan index idx; when scan_en_i=1, visit channel idx and set idx to idx+1, wrapping NumCh-1 to 0; when scan_en_i=0, hold idx and all channel state.
REQ-022 On visit: raw!=sample -> ctr=0, sample=raw; else ctr==thresh -> ctr held (saturate); else ctr=ctr+1.
REQ-023 On visit: if next ctr==thresh and raw!=stored, stored=raw and one event {idx, raw} SHALL be pushed.
REQ-024 thresh=0 SHALL update stored at the first visit that observes the change.
REQ-025 Filtering SHALL run regardless of en; filt_o[c] = en[c] ? stored[c] : raw_i[c], combinational.
REQ-026 Config write SHALL update en and thresh of cfg_ch_i at next edge and clear that channel's ctr; a write to the channel visited in the same cycle SHALL win over the visit's ctr update (sample/stored update and event push still occur).
REQ-027 cfg_ch_i >= NumCh SHALL be ignored.
REQ-028 Events SHALL leave in push order; head transfers when evt_valid_o and evt_ready_i both high.
REQ-029 Push into full queue with no pop same cycle SHALL drop the event and set ovf_o next cycle; push with pop on full SHALL be accepted.
REQ-030 ovf_clr_i SHALL clear ovf_o; simultaneous drop and clear SHALL leave ovf_o=1.
REQ-031 Latency: raw edge held stable -> stored update after (thresh+1) visits, at most (thresh+1)*NumCh+NumCh cycles; event visible on evt_valid_o the cycle after the update.

Reset
REQ-032 rst_i SHALL set idx=0, all sample/stored/ctr/en=0, all thresh=DefThresh, queue empty, ovf_o=0.
REQ-033 Outputs after reset: filt_o=raw_i, evt_valid_o=0, evt_ch_o=0, evt_val_o=0, ovf_o=0.
REQ-034 Reset mid-operation SHALL discard queued events with no partial transfer.

Structure
REQ-035 Package filter_scan_pkg SHALL hold evt_t {ch, val} and the default parameter constants.
REQ-036 Event queue SHALL be sub-module filter_evt_fifo (synchronous, valid/ready, full/empty flags).
REQ-037 Channel state SHALL use flop arrays indexed by idx; one shared counter/compare datapath.

Verification (NumCh=4, thresh=2, en=1, scan_en_i=1 unless stated)
REQ-038 raw_i[1] 0->1 held -> stored[1]=1, filt_o[1]=1 after 3rd visit of ch1, one event {1,1}.
REQ-039 raw_i[2] 1-cycle-per-visit toggling pulse shorter than 3 visits -> filt_o[2] stays 0, no event.
REQ-040 Five channel edges with evt_ready_i=0, EvtDepth=4 -> 4 events queued in order, ovf_o=1; ovf_clr_i -> ovf_o=0.
REQ-041 en[3]=0, raw_i[3]=1 -> filt_o[3]=1 immediately; set en[3]=1 -> filt_o[3]=stored[3].
REQ-042 cfg write thresh=0 to ch0 while ctr0=1, then raw_i[0] edge -> update and event at next ch0 visit.
REQ-043 scan_en_i=0 for 20 cycles with raw edge -> no state change, no event; resumes at held idx.

Source files
------------

// File: rtl/filter_scan_pkg.sv
// Shared types and default parameters for the scanned input filter.
package filter_scan_pkg;

  localparam int unsigned DefNumCh     = 8;
  localparam int unsigned DefCtrWidth  = 8;
  localparam int unsigned DefThreshVal = 3;
  localparam int unsigned DefEvtDepth  = 4;

  // Event channel field is sized for the widest supported channel count.
  localparam int unsigned EvtChW = 8;

  typedef struct packed {
    logic [EvtChW-1:0] ch;
    logic              val;
  } evt_t;

  localparam int unsigned EvtW = $bits(evt_t);

endpackage

// File: rtl/filter_evt_fifo.sv
// Synchronous valid/ready event queue; head reads as zero while empty.
module filter_evt_fifo
  import filter_scan_pkg::*;
#(
  parameter int unsigned Depth = DefEvtDepth
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [EvtW-1:0] wdata_i,
  input  logic            pop_i,
  output logic            valid_o,
  output logic [EvtW-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            drop_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   cnt_q;
  logic [EvtW-1:0]  mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AddrW + 1)'(Depth));
  assign valid_o = !empty_o;
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AddrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AddrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/filter_scan_ctrl.sv
// Round-robin debounce filter: one shared counter datapath visits a channel per enabled cycle
// and queues an event whenever a channel's stored value changes.
module filter_scan_ctrl
  import filter_scan_pkg::*;
#(
  parameter int unsigned NumCh     = DefNumCh,
  parameter int unsigned CtrWidth  = DefCtrWidth,
  parameter int unsigned DefThresh = DefThreshVal,
  parameter int unsigned EvtDepth  = DefEvtDepth,
  localparam int unsigned ChW      = $clog2(NumCh)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumCh-1:0]    raw_i,
  input  logic                scan_en_i,
  input  logic                cfg_we_i,
  input  logic [ChW-1:0]      cfg_ch_i,
  input  logic                cfg_en_i,
  input  logic [CtrWidth-1:0] cfg_thresh_i,
  output logic [NumCh-1:0]    filt_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [ChW-1:0]      evt_ch_o,
  output logic                evt_val_o,
  output logic                ovf_o,
  input  logic                ovf_clr_i
);

  logic [ChW-1:0]      idx_q, idx_nxt;
  logic [NumCh-1:0]    sample_q, stored_q, en_q;
  logic [CtrWidth-1:0] ctr_q    [NumCh];
  logic [CtrWidth-1:0] thresh_q [NumCh];
  logic                ovf_q;

  logic                cur_raw, upd, push, cfg_hit, drop;
  logic [CtrWidth-1:0] ctr_cur, thr_cur, ctr_nxt;
  evt_t                push_evt, head_evt;
  logic                fifo_full, fifo_empty;

  always_comb begin
    cur_raw = raw_i[idx_q];
    ctr_cur = ctr_q[idx_q];
    thr_cur = thresh_q[idx_q];
    if (cur_raw != sample_q[idx_q]) begin
      ctr_nxt = '0;
    end else if (ctr_cur == thr_cur) begin
      ctr_nxt = ctr_cur;
    end else begin
      ctr_nxt = ctr_cur + CtrWidth'(1);
    end
    upd     = (ctr_nxt == thr_cur) && (cur_raw != stored_q[idx_q]);
    push    = scan_en_i && upd;
    idx_nxt = (idx_q == ChW'(NumCh - 1)) ? '0 : idx_q + ChW'(1);
    cfg_hit = cfg_we_i && (32'(cfg_ch_i) < NumCh);
    push_evt.ch  = EvtChW'(idx_q);
    push_evt.val = cur_raw;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      sample_q <= '0;
      stored_q <= '0;
      en_q     <= '0;
      for (int i = 0; i < NumCh; i++) begin
        ctr_q[i]    <= '0;
        thresh_q[i] <= CtrWidth'(DefThresh);
      end
    end else begin
      if (scan_en_i) begin
        sample_q[idx_q] <= cur_raw;
        ctr_q[idx_q]    <= ctr_nxt;
        if (upd) stored_q[idx_q] <= cur_raw;
        idx_q <= idx_nxt;
      end
      // Placed after the visit so a config write to the visited channel wins on ctr.
      if (cfg_hit) begin
        en_q[cfg_ch_i]     <= cfg_en_i;
        thresh_q[cfg_ch_i] <= cfg_thresh_i;
        ctr_q[cfg_ch_i]    <= '0;
      end
    end
  end

  filter_evt_fifo #(
    .Depth (EvtDepth)
  ) u_evt_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (push_evt),
    .pop_i   (evt_ready_i),
    .valid_o (evt_valid_o),
    .rdata_o (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (drop)
  );

  // A drop outranks a same-cycle clear so no lost event goes unreported.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign filt_o    = (en_q & stored_q) | (~en_q & raw_i);
  assign evt_ch_o  = head_evt.ch[ChW-1:0];
  assign evt_val_o = head_evt.val;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Directed bench: expected events go into a scoreboard queue checked by a handshake monitor.
module tb_filter_scan_ctrl;

  localparam int unsigned NumCh = 4;
  localparam int unsigned CtrW  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      raw;
  logic            scan_en, cfg_we, cfg_en, evt_ready, ovf_clr;
  logic [1:0]      cfg_ch;
  logic [CtrW-1:0] cfg_thresh;
  logic [3:0]      filt;
  logic            evt_valid, evt_val, ovf;
  logic [1:0]      evt_ch;

  int tests = 0;
  int fails = 0;
  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  filter_scan_ctrl #(
    .NumCh     (NumCh),
    .CtrWidth  (CtrW),
    .DefThresh (3),
    .EvtDepth  (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .raw_i        (raw),
    .scan_en_i    (scan_en),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_en_i     (cfg_en),
    .cfg_thresh_i (cfg_thresh),
    .filt_o       (filt),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_ch_o     (evt_ch),
    .evt_val_o    (evt_val),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic en, input logic [CtrW-1:0] thr);
    cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_thresh = thr;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; scan_en = 1'b0; cfg_we = 1'b0; ovf_clr = 1'b0; raw = 4'b0000;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) cfg_write(2'(c), 1'b1, 8'd2);
  endtask

  task automatic check_drained(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head event must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_evt: got ch=%0d val=%0d required no event", evt_ch, evt_val);
      end else begin
        check("evt_order", {evt_ch, evt_val}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; raw = 4'b0101; scan_en = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_en = 1'b0; cfg_thresh = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    tick(2);
    check("rst_filt_eq_raw", filt, 4'b0101);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_ch", evt_ch, 0);
    check("rst_evt_val", evt_val, 0);
    check("rst_ovf", ovf, 0);

    // Stable edge on ch1 commits at its third visit (edge 10).
    do_reset();
    evt_ready = 1'b1;
    raw = 4'b0010; scan_en = 1'b1;
    exp_q.push_back({2'd1, 1'b1});
    tick(9);
    check("a_filt1_before", filt[1], 0);
    tick(1);
    check("a_filt1_after", filt[1], 1);
    scan_en = 1'b0;
    check_drained("a_drain");

    // Pulse on ch2 seen by only two visits is rejected.
    do_reset();
    raw = 4'b0100; scan_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("b_filt2_high", filt[2], 0);
    end
    raw = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("b_filt2_low", filt[2], 0);
    end
    scan_en = 1'b0;
    check_drained("b_drain");

    // Four events fill the queue; a fifth is dropped while a clear is also asserted.
    do_reset();
    evt_ready = 1'b0;
    raw = 4'b1111; scan_en = 1'b1;
    for (int c = 0; c < 4; c++) exp_q.push_back({2'(c), 1'b1});
    tick(12);
    check("c_valid_full", evt_valid, 1);
    check("c_head_ch", evt_ch, 0);
    raw = 4'b1110;
    tick(8);
    check("c_ovf_before", ovf, 0);
    ovf_clr = 1'b1;
    tick(1);
    check("c_ovf_drop_beats_clr", ovf, 1);
    scan_en = 1'b0;
    tick(1);
    check("c_ovf_cleared", ovf, 0);
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    check_drained("c_drain");

    // Disabled channel passes raw straight through.
    do_reset();
    cfg_write(2'd3, 1'b0, 8'd2);
    raw = 4'b1000;
    #1;
    check("d_bypass", filt[3], 1);
    cfg_write(2'd3, 1'b1, 8'd2);
    check("d_filtered", filt[3], 0);
    raw = 4'b0000;

    // thresh=0 written over a nonzero counter: ch0 commits on its next visit.
    do_reset();
    scan_en = 1'b1;
    tick(1);
    scan_en = 1'b0;
    cfg_write(2'd0, 1'b1, 8'd0);
    raw = 4'b0001; scan_en = 1'b1;
    exp_q.push_back({2'd0, 1'b1});
    tick(3);
    check("e_filt0_before", filt[0], 0);
    tick(1);
    check("e_filt0_after", filt[0], 1);
    scan_en = 1'b0;
    check_drained("e_drain");

    // Paused scan holds everything; resumes visiting ch2 first.
    do_reset();
    scan_en = 1'b1;
    tick(2);
    scan_en = 1'b0;
    raw = 4'b0100;
    tick(20);
    check("f_paused_filt2", filt[2], 0);
    check("f_paused_valid", evt_valid, 0);
    exp_q.push_back({2'd2, 1'b1});
    scan_en = 1'b1;
    tick(8);
    check("f_resume_before", filt[2], 0);
    tick(1);
    check("f_resume_after", filt[2], 1);
    scan_en = 1'b0;
    check_drained("f_drain");

    // Reset with a full queue discards it without any transfer.
    do_reset();
    evt_ready = 1'b0;
    raw = 4'b1111; scan_en = 1'b1;
    tick(12);
    check("g_queued", evt_valid, 1);
    do_reset();
    check("g_flushed", evt_valid, 0);
    evt_ready = 1'b1;
    tick(3);
    check("g_still_empty", evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
